// File: rtl/alu_pkg.sv
// Shared types for the handshaked multi-cycle ALU: opcodes, FSM states and flag bit positions.
package alu_pkg;

   typedef enum logic [2:0] {
      OP_ADD   = 3'b000,
      OP_SUB   = 3'b001,
      OP_AND   = 3'b010,
      OP_OR    = 3'b011,
      OP_MUL   = 3'b100,
      OP_PASSB = 3'b101,
      OP_XOR   = 3'b110,
      OP_CMP   = 3'b111
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DONE = 2'd2
   } alu_state_e;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_shift_add_mul.sv
// Iterative shift-add multiplier producing the low WIDTH bits of a*b, one multiplier bit per cycle.
// done is high during the final iteration; product then already includes that iteration's add.
module alu_shift_add_mul #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] product
);

   logic [WIDTH-1:0] mcand_reg;
   logic [WIDTH-1:0] mplier_reg;
   logic [WIDTH-1:0] acc_reg;
   logic [WIDTH-1:0] acc_next;
   logic [CNT_W-1:0] cnt_reg;
   logic             run_reg;

   assign acc_next = mplier_reg[0] ? (acc_reg + mcand_reg) : acc_reg;
   assign done     = run_reg && (cnt_reg == CNT_W'(1));
   assign product  = acc_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         mcand_reg  <= '0;
         mplier_reg <= '0;
         acc_reg    <= '0;
         cnt_reg    <= '0;
         run_reg    <= 1'b0;
      end else if (start) begin
         mcand_reg  <= a;
         mplier_reg <= b;
         acc_reg    <= '0;
         cnt_reg    <= CNT_W'(WIDTH);
         run_reg    <= 1'b1;
      end else if (run_reg) begin
         acc_reg    <= acc_next;
         mcand_reg  <= mcand_reg << 1;
         mplier_reg <= mplier_reg >> 1;
         cnt_reg    <= cnt_reg - CNT_W'(1);
         // Stop once the counter reaches zero; the top latches product on that same edge.
         run_reg    <= (cnt_reg != CNT_W'(1));
      end
   end

endmodule

// File: rtl/alu_multicycle.sv
// Handshaked ALU: single-cycle ops complete in one clock, multiply uses an iterative engine.
// Define ALU_MUL_EN to build the multiplier; otherwise sel=100 completes at once with out_err=1.
module alu_multicycle
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       sel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       flag,
   output logic             out_err
);

   if (WIDTH < 4 || CNT_W < $clog2(WIDTH + 1)) begin : g_param_check
      $error("alu_multicycle: WIDTH must be >= 4 and CNT_W wide enough to hold WIDTH");
   end

   alu_state_e       state_reg;
   alu_state_e       state_next;
   logic             accept;
   logic             is_mul;
   logic             mul_path;
   logic             mul_done;
   logic [WIDTH-1:0] mul_product;

   logic             is_sub;
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH:0]   sum_ext;
   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] op_res;
   logic [WIDTH-1:0] nz_src;
   logic             op_c;
   logic             op_v;
   logic             op_err;
   logic [3:0]       op_flag;
   logic [3:0]       mul_flag;

   logic [WIDTH-1:0] result_reg;
   logic [3:0]       flag_reg;
   logic             err_reg;

   assign is_mul = (sel == OP_MUL);
   assign accept = in_valid && (state_reg == ST_IDLE);

`ifdef ALU_MUL_EN
   assign mul_path = is_mul;

   alu_shift_add_mul #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (accept && is_mul),
      .a       (a),
      .b       (b),
      .done    (mul_done),
      .product (mul_product)
   );
`else
   assign mul_path    = 1'b0;
   assign mul_done    = 1'b0;
   assign mul_product = '0;
`endif

   // Sub and cmp share the adder with an inverted B and carry-in of one.
   always_comb begin
      is_sub  = (sel == OP_SUB) || (sel == OP_CMP);
      b_eff   = is_sub ? ~b : b;
      sum_ext = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
      sum     = sum_ext[WIDTH-1:0];
   end

   always_comb begin
      op_res = '0;
      nz_src = '0;
      op_c   = 1'b0;
      op_v   = 1'b0;
      op_err = 1'b0;
      case (alu_op_e'(sel))
         OP_ADD, OP_SUB: begin
            op_res = sum;
            nz_src = sum;
            op_c   = sum_ext[WIDTH];
            op_v   = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_CMP: begin
            op_res = a;
            nz_src = sum;
            op_c   = sum_ext[WIDTH];
            op_v   = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND:   begin op_res = a & b; nz_src = a & b; end
         OP_OR:    begin op_res = a | b; nz_src = a | b; end
         OP_XOR:   begin op_res = a ^ b; nz_src = a ^ b; end
         OP_PASSB: begin op_res = b;     nz_src = b;     end
         OP_MUL:   op_err = 1'b1;
         default:  op_err = 1'b1;
      endcase

      op_flag         = 4'b0000;
      op_flag[FLAG_N] = nz_src[WIDTH-1];
      op_flag[FLAG_Z] = (nz_src == '0);
      op_flag[FLAG_C] = op_c;
      op_flag[FLAG_V] = op_v;

      mul_flag         = 4'b0000;
      mul_flag[FLAG_N] = mul_product[WIDTH-1];
      mul_flag[FLAG_Z] = (mul_product == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: if (in_valid)  state_next = mul_path ? ST_MUL : ST_DONE;
         ST_MUL:  if (mul_done)  state_next = ST_DONE;
         ST_DONE: if (out_ready) state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_reg == ST_IDLE);
      out_valid = (state_reg == ST_DONE);
   end

   // Output registers change only on completion, so they hold through any backpressure.
   always_ff @(posedge clk) begin
      if (rst) begin
         result_reg <= '0;
         flag_reg   <= 4'b0000;
         err_reg    <= 1'b0;
      end else if (accept && !mul_path) begin
         result_reg <= op_res;
         flag_reg   <= op_flag;
         err_reg    <= op_err;
      end else if ((state_reg == ST_MUL) && mul_done) begin
         result_reg <= mul_product;
         flag_reg   <= mul_flag;
         err_reg    <= 1'b0;
      end
   end

   assign result  = result_reg;
   assign flag    = flag_reg;
   assign out_err = err_reg;

endmodule
